// File: rtl/pwm_duty_ctrl.sv
`default_nettype none
//------------------------------------------------------------------------------
// pwm_duty_ctrl - debounced increase/decrease switches with auto-repeat drive a
// saturating 4-bit duty step for a PWM generator.          Revision: 1.0
//------------------------------------------------------------------------------
module pwm_duty_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned REPEAT_CYCLES   = 20,
  parameter int unsigned DUTY_MAX        = 10,
  parameter int unsigned DUTY_INIT       = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       swt_increase,
  input  logic       swt_decrease,
  output logic [3:0] duty,
  output logic       duty_update,
  output logic       at_max,
  output logic       at_min
);

  localparam logic [3:0]  c_DUTY_MAX  = 4'(DUTY_MAX);
  localparam logic [3:0]  c_DUTY_INIT = 4'(DUTY_INIT);
  localparam logic [7:0]  c_DEB_LAST  = 8'(DEBOUNCE_CYCLES - 1);
  localparam logic [15:0] c_REP_LAST  = 16'(REPEAT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_INC_HOLD = 2'd1,
    S_DEC_HOLD = 2'd2,
    S_LOCK     = 2'd3
  } state_t;

  logic [1:0] sw_raw;
  logic [1:0] deb;
  logic [1:0] deb_prev_q;
  logic [1:0] press;

  assign sw_raw = {swt_decrease, swt_increase};

  // Bit 0 is the increase switch, bit 1 the decrease switch.
  generate
    for (genvar g = 0; g < 2; g++) begin : g_switch
      logic [1:0] sync_q;
      logic [7:0] cnt_q;
      logic       deb_q;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          sync_q <= 2'b00;
          cnt_q  <= 8'd0;
          deb_q  <= 1'b0;
        end else begin
          sync_q <= {sync_q[0], sw_raw[g]};
          if (sync_q[1] != deb_q) begin
            if (cnt_q == c_DEB_LAST) begin
              deb_q <= sync_q[1];
              cnt_q <= 8'd0;
            end else begin
              cnt_q <= cnt_q + 8'd1;
            end
          end else begin
            cnt_q <= 8'd0;
          end
        end
      end

      assign deb[g] = deb_q;
    end
  endgenerate

  assign press = deb & ~deb_prev_q;

  state_t      state_q, state_d;
  logic [15:0] rep_q, rep_d;
  logic [3:0]  duty_q, duty_d;
  logic        upd_q, upd_d;
  logic        at_max_q, at_min_q;
  logic        inc_req, dec_req;

  always_comb begin
    state_d = state_q;
    rep_d   = rep_q;
    inc_req = 1'b0;
    dec_req = 1'b0;
    case (state_q)
      S_IDLE: begin
        rep_d = 16'd0;
        if ((press[0] && press[1]) || (deb[0] && deb[1])) begin
          state_d = S_LOCK;
        end else if (press[0]) begin
          inc_req = 1'b1;
          state_d = S_INC_HOLD;
        end else if (press[1]) begin
          dec_req = 1'b1;
          state_d = S_DEC_HOLD;
        end
      end
      S_INC_HOLD: begin
        if (deb[1]) begin
          state_d = S_LOCK;
        end else if (!deb[0]) begin
          state_d = S_IDLE;
        end else if (rep_q == c_REP_LAST) begin
          inc_req = 1'b1;
          rep_d   = 16'd0;
        end else begin
          rep_d = rep_q + 16'd1;
        end
      end
      S_DEC_HOLD: begin
        if (deb[0]) begin
          state_d = S_LOCK;
        end else if (!deb[1]) begin
          state_d = S_IDLE;
        end else if (rep_q == c_REP_LAST) begin
          dec_req = 1'b1;
          rep_d   = 16'd0;
        end else begin
          rep_d = rep_q + 16'd1;
        end
      end
      S_LOCK: begin
        rep_d = 16'd0;
        if (deb == 2'b00) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // A saturated step leaves duty untouched and raises no update pulse.
  always_comb begin
    duty_d = duty_q;
    upd_d  = 1'b0;
    if (inc_req && (duty_q != c_DUTY_MAX)) begin
      duty_d = duty_q + 4'd1;
      upd_d  = 1'b1;
    end else if (dec_req && (duty_q != 4'd0)) begin
      duty_d = duty_q - 4'd1;
      upd_d  = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      rep_q      <= 16'd0;
      deb_prev_q <= 2'b00;
      duty_q     <= c_DUTY_INIT;
      upd_q      <= 1'b0;
      at_max_q   <= (c_DUTY_INIT == c_DUTY_MAX);
      at_min_q   <= (c_DUTY_INIT == 4'd0);
    end else begin
      state_q    <= state_d;
      rep_q      <= rep_d;
      deb_prev_q <= deb;
      duty_q     <= duty_d;
      upd_q      <= upd_d;
      at_max_q   <= (duty_d == c_DUTY_MAX);
      at_min_q   <= (duty_d == 4'd0);
    end
  end

  assign duty        = duty_q;
  assign duty_update = upd_q;
  assign at_max      = at_max_q;
  assign at_min      = at_min_q;

endmodule
`default_nettype wire

// File: tb/tb_pwm_duty_ctrl.sv
`default_nettype none
//------------------------------------------------------------------------------
// tb_pwm_duty_ctrl - scenario and randomized bench for pwm_duty_ctrl against a
// cycle-timed behavioural model.                           Revision: 1.0
//------------------------------------------------------------------------------
module tb_pwm_duty_ctrl;

  localparam int D     = 4;
  localparam int R     = 20;
  localparam int DMAX  = 10;
  localparam int DINIT = 5;

  localparam int M_IDLE = 0;
  localparam int M_INC  = 1;
  localparam int M_DEC  = 2;
  localparam int M_LOCK = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic       swt_increase;
  logic       swt_decrease;
  logic [3:0] duty;
  logic       duty_update;
  logic       at_max;
  logic       at_min;
  logic [6:0] dut_vec;

  int n_tests = 0;
  int n_fail  = 0;

  pwm_duty_ctrl #(
    .DEBOUNCE_CYCLES(D),
    .REPEAT_CYCLES  (R),
    .DUTY_MAX       (DMAX),
    .DUTY_INIT      (DINIT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .swt_increase(swt_increase),
    .swt_decrease(swt_decrease),
    .duty        (duty),
    .duty_update (duty_update),
    .at_max      (at_max),
    .at_min      (at_min)
  );

  always #5 clk = ~clk;

  assign dut_vec = {duty, duty_update, at_max, at_min};

  // Reference model: raw samples reach the debouncer two edges late; a level
  // flips once the last D seen samples all disagree with it.
  int m_duty, m_mode, m_next, m_ecount;
  bit m_upd, m_deb_i, m_deb_d, m_old_i, m_old_d;
  bit m_raw_i[$], m_raw_d[$], m_seen_i[$], m_seen_d[$];

  function automatic bit window_differs(input bit seen[$], input bit level);
    if (seen.size() < D) return 1'b0;
    for (int j = seen.size() - D; j < seen.size(); j++)
      if (seen[j] == level) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [6:0] model_vec();
    return {4'(m_duty), m_upd, (m_duty == DMAX), (m_duty == 0)};
  endfunction

  task automatic model_reset();
    m_duty = DINIT; m_mode = M_IDLE; m_next = 0; m_ecount = 0; m_upd = 1'b0;
    m_deb_i = 1'b0; m_deb_d = 1'b0; m_old_i = 1'b0; m_old_d = 1'b0;
    m_raw_i.delete(); m_raw_d.delete(); m_seen_i.delete(); m_seen_d.delete();
  endtask

  task automatic model_step(input bit ri, input bit rd);
    int step;
    bit pi, pd, si, sd;
    m_ecount++;
    pi = m_deb_i && !m_old_i;
    pd = m_deb_d && !m_old_d;
    step = 0;
    case (m_mode)
      M_IDLE: begin
        if ((pi && pd) || (m_deb_i && m_deb_d)) m_mode = M_LOCK;
        else if (pi) begin step = 1;  m_mode = M_INC; m_next = m_ecount + R; end
        else if (pd) begin step = -1; m_mode = M_DEC; m_next = m_ecount + R; end
      end
      M_INC: begin
        if (m_deb_d) m_mode = M_LOCK;
        else if (!m_deb_i) m_mode = M_IDLE;
        else if (m_ecount == m_next) begin step = 1; m_next = m_next + R; end
      end
      M_DEC: begin
        if (m_deb_i) m_mode = M_LOCK;
        else if (!m_deb_d) m_mode = M_IDLE;
        else if (m_ecount == m_next) begin step = -1; m_next = m_next + R; end
      end
      default: if (!m_deb_i && !m_deb_d) m_mode = M_IDLE;
    endcase
    m_upd = 1'b0;
    if (step > 0 && m_duty < DMAX) begin m_duty++; m_upd = 1'b1; end
    else if (step < 0 && m_duty > 0) begin m_duty--; m_upd = 1'b1; end
    m_old_i = m_deb_i;
    m_old_d = m_deb_d;
    si = (m_raw_i.size() >= 2) ? m_raw_i[m_raw_i.size() - 2] : 1'b0;
    sd = (m_raw_d.size() >= 2) ? m_raw_d[m_raw_d.size() - 2] : 1'b0;
    m_seen_i.push_back(si); m_seen_d.push_back(sd);
    m_raw_i.push_back(ri);  m_raw_d.push_back(rd);
    if (m_raw_i.size() > 2) begin void'(m_raw_i.pop_front()); void'(m_raw_d.pop_front()); end
    if (m_seen_i.size() > 300) begin void'(m_seen_i.pop_front()); void'(m_seen_d.pop_front()); end
    if (window_differs(m_seen_i, m_deb_i)) m_deb_i = !m_deb_i;
    if (window_differs(m_seen_d, m_deb_d)) m_deb_d = !m_deb_d;
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst) model_reset();
    else model_step(swt_increase, swt_decrease);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1; swt_increase = 1'b0; swt_decrease = 1'b0;
    model_reset();
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; swt_increase = 1'b0; swt_decrease = 1'b0;
    model_reset();
    #1;
    n_tests++;
    if (dut_vec !== 7'b0101_000) begin
      n_fail++; $display("FAIL reset_hold: got %b expected %b", dut_vec, 7'b0101_000);
    end
    tick(); tick();
    rst = 1'b0;
    for (int i = 0; i < 100; i++) begin
      tick();
      n_tests++;
      if (dut_vec !== 7'b0101_000 || dut_vec !== model_vec()) begin
        n_fail++; $display("FAIL reset_idle cyc %0d: got %b expected %b", i, dut_vec, 7'b0101_000);
      end
    end
  endtask

  task automatic test_single_press();
    int first_edge, pulses;
    logic [3:0] prev;
    apply_reset();
    first_edge = -1; pulses = 0; prev = duty;
    swt_increase = 1'b1;
    for (int e = 1; e <= 50; e++) begin
      if (e == 11) swt_increase = 1'b0;
      tick();
      if (duty !== prev && first_edge < 0) first_edge = e;
      prev = duty;
      if (duty_update === 1'b1) pulses++;
      n_tests++;
      if (dut_vec !== model_vec()) begin
        n_fail++; $display("FAIL single_press_model edge %0d: got %b expected %b", e, dut_vec, model_vec());
      end
    end
    n_tests++;
    if (first_edge != D + 3) begin
      n_fail++; $display("FAIL single_press_latency: got edge %0d expected %0d", first_edge, D + 3);
    end
    n_tests++;
    if (pulses != 1 || duty !== 4'd6) begin
      n_fail++; $display("FAIL single_press_result: got pulses %0d duty %0d expected 1 and 6", pulses, duty);
    end
  endtask

  task automatic test_glitch();
    int pulses;
    apply_reset();
    pulses = 0;
    for (int i = 0; i < 23; i++) begin
      swt_decrease = (i < 3);
      tick();
      if (duty_update === 1'b1) pulses++;
    end
    n_tests++;
    if (pulses != 0 || duty !== 4'd5) begin
      n_fail++; $display("FAIL glitch_reject: got pulses %0d duty %0d expected 0 and 5", pulses, duty);
    end
    for (int i = 0; i < 60; i++) begin
      swt_decrease = (i < 20) ? 1'(i % 2) : (i < 35);
      tick();
      if (duty_update === 1'b1) pulses++;
      n_tests++;
      if (dut_vec !== model_vec()) begin
        n_fail++; $display("FAIL glitch_model cyc %0d: got %b expected %b", i, dut_vec, model_vec());
      end
    end
    n_tests++;
    if (pulses != 1 || duty !== 4'd4) begin
      n_fail++; $display("FAIL glitch_bounce: got pulses %0d duty %0d expected 1 and 4", pulses, duty);
    end
  endtask

  task automatic test_auto_repeat();
    int edges[$];
    int vals[$];
    apply_reset();
    swt_increase = 1'b1;
    for (int e = 1; e <= 230; e++) begin
      if (e == 201) swt_increase = 1'b0;
      tick();
      if (duty_update === 1'b1) begin edges.push_back(e); vals.push_back(int'(duty)); end
      n_tests++;
      if (dut_vec !== model_vec()) begin
        n_fail++; $display("FAIL repeat_model edge %0d: got %b expected %b", e, dut_vec, model_vec());
      end
    end
    n_tests++;
    if (edges.size() != 5) begin
      n_fail++; $display("FAIL repeat_count: got %0d pulses expected 5", edges.size());
    end else begin
      for (int k = 0; k < 5; k++) begin
        n_tests++;
        if (edges[k] != D + 3 + k * R || vals[k] != 6 + k) begin
          n_fail++; $display("FAIL repeat_step %0d: got edge %0d duty %0d expected edge %0d duty %0d",
                             k, edges[k], vals[k], D + 3 + k * R, 6 + k);
        end
      end
    end
    n_tests++;
    if (at_max !== 1'b1 || duty !== 4'd10 || at_min !== 1'b0) begin
      n_fail++; $display("FAIL repeat_at_max: got at_max %b duty %0d expected 1 and 10", at_max, duty);
    end
  endtask

  task automatic test_lock();
    int pulses;
    apply_reset();
    pulses = 0;
    swt_increase = 1'b1; swt_decrease = 1'b1;
    for (int i = 0; i < 90; i++) begin
      if (i == 30) swt_decrease = 1'b0;
      tick();
      if (duty_update === 1'b1) pulses++;
      n_tests++;
      if (dut_vec !== model_vec()) begin
        n_fail++; $display("FAIL lock_model cyc %0d: got %b expected %b", i, dut_vec, model_vec());
      end
    end
    n_tests++;
    if (pulses != 0 || duty !== 4'd5) begin
      n_fail++; $display("FAIL lock_hold: got pulses %0d duty %0d expected 0 and 5", pulses, duty);
    end
    swt_increase = 1'b0;
    for (int i = 0; i < 62; i++) begin
      swt_decrease = (i >= 20 && i < 32);
      tick();
      if (duty_update === 1'b1) pulses++;
    end
    n_tests++;
    if (pulses != 1 || duty !== 4'd4) begin
      n_fail++; $display("FAIL lock_exit: got pulses %0d duty %0d expected 1 and 4", pulses, duty);
    end
  endtask

  task automatic test_reset_mid_hold();
    int guard, first_edge;
    logic [3:0] prev;
    apply_reset();
    swt_decrease = 1'b1;
    guard = 0;
    while (duty !== 4'd2 && guard < 100) begin tick(); guard++; end
    n_tests++;
    if (duty !== 4'd2) begin
      n_fail++; $display("FAIL midhold_reach: got duty %0d expected 2 within 100 cycles", duty);
    end
    rst = 1'b1;
    model_reset();
    #1;
    n_tests++;
    if (dut_vec !== 7'b0101_000) begin
      n_fail++; $display("FAIL midhold_async: got %b expected %b", dut_vec, 7'b0101_000);
    end
    tick(); tick();
    rst = 1'b0;
    first_edge = -1; prev = duty;
    for (int e = 1; e <= 12; e++) begin
      tick();
      if (duty !== prev && first_edge < 0) first_edge = e;
      prev = duty;
    end
    n_tests++;
    if (first_edge != D + 3 || duty !== 4'd4) begin
      n_fail++; $display("FAIL midhold_repress: got edge %0d duty %0d expected edge %0d duty 4",
                         first_edge, duty, D + 3);
    end
    swt_decrease = 1'b0;
    repeat (20) tick();
  endtask

  task automatic test_random();
    int len;
    apply_reset();
    for (int s = 0; s < 120; s++) begin
      if ($urandom_range(0, 14) == 0) begin
        rst = 1'b1;
        model_reset();
        repeat ($urandom_range(1, 2)) tick();
        rst = 1'b0;
      end
      swt_increase = 1'($urandom_range(0, 1));
      swt_decrease = 1'($urandom_range(0, 1));
      len = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 3)) : int'($urandom_range(4, 60));
      for (int c = 0; c < len; c++) begin
        tick();
        n_tests++;
        if (dut_vec !== model_vec()) begin
          n_fail++; $display("FAIL random_model seg %0d cyc %0d: got %b expected %b", s, c, dut_vec, model_vec());
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1; swt_increase = 1'b0; swt_decrease = 1'b0;
    model_reset();
    test_reset();
    test_single_press();
    test_glitch();
    test_auto_repeat();
    test_lock();
    test_reset_mid_hold();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pwm_duty_ctrl.md
PWM_DUTY_CTRL -- requirements
Module: pwm_duty_ctrl

Interface
REQ-001 The block SHALL have the parameter DEBOUNCE_CYCLES, default 4: the number of consecutive stable samples needed to accept a switch level change; legal range 1..255.
REQ-002 The block SHALL have the parameter REPEAT_CYCLES, default 20: the number of cycles between auto-repeat steps while one switch is held; legal range 2..65535.
REQ-003 The block SHALL have the parameter DUTY_MAX, default 10: the top duty step, where 1 step = 10%; legal range 1..15.
REQ-004 The block SHALL have the parameter DUTY_INIT, default 5: the duty step loaded on reset; DUTY_INIT SHALL be <= DUTY_MAX.
REQ-005 The block SHALL have the port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-006 The block SHALL have the port rst, input, 1 bit: asynchronous, active-high reset.
REQ-007 The block SHALL have the port swt_increase, input, 1 bit: a raw, asynchronous, bouncing increase switch; active high.
REQ-008 The block SHALL have the port swt_decrease, input, 1 bit: a raw, asynchronous, bouncing decrease switch; active high.
REQ-009 The block SHALL have the port duty, output, 4 bits: the current duty step 0..DUTY_MAX, which feeds the PWM generator's duty setting.
REQ-010 The block SHALL have the port duty_update, output, 1 bit: a one-cycle pulse, high in the first cycle that duty holds a new value.
REQ-011 The block SHALL have the port at_max, output, 1 bit: high iff duty == DUTY_MAX.
REQ-012 The block SHALL have the port at_min, output, 1 bit: high iff duty == 0.

Function
REQ-013 Each switch SHALL pass through its own 2-flop synchronizer before any other use.
REQ-014 Each synchronized switch SHALL drive its own debounce counter; the debounced level SHALL change on the DEBOUNCE_CYCLES-th consecutive rising edge at which the synchronized value differs from the debounced level, and any sample equal to the debounced level SHALL clear that counter.
REQ-015 A "press" SHALL be a 0->1 transition of a debounced level; a "release" SHALL be a 1->0 transition.
REQ-016 The FSM SHALL have four states: IDLE, INC_HOLD, DEC_HOLD and LOCK.
REQ-017 In IDLE, a press of increase alone SHALL perform an increment step and move the FSM to INC_HOLD; a press of decrease alone SHALL perform a decrement step and move the FSM to DEC_HOLD.
REQ-018 In IDLE, presses of both switches in the same cycle, or both debounced levels high, SHALL move the FSM to LOCK with no step.
REQ-019 In INC_HOLD, the repeat counter SHALL restart on entry; each time it reaches REPEAT_CYCLES the block SHALL perform one increment step and the counter SHALL restart.
REQ-020 In INC_HOLD, a release of increase SHALL return the FSM to IDLE, and a debounced decrease going high SHALL move the FSM to LOCK with no step.
REQ-021 DEC_HOLD SHALL behave as INC_HOLD with the two switches swapped and decrement steps.
REQ-022 In LOCK, no step SHALL occur; the FSM SHALL return to IDLE only when both debounced levels are 0, and releasing only one switch SHALL keep the FSM in LOCK.
REQ-023 An increment SHALL saturate at DUTY_MAX and a decrement SHALL saturate at 0; a saturated step SHALL leave duty unchanged and SHALL NOT pulse duty_update.
REQ-024 duty, duty_update, at_max and at_min SHALL be registered together; duty_update SHALL be high in exactly the cycle in which duty first shows a changed value.
REQ-025 Press latency SHALL be fixed: from a raw rising edge of a switch that then holds stable, duty SHALL change on rising edge number DEBOUNCE_CYCLES+3 (7 with the defaults).
REQ-026 Auto-repeat steps SHALL occur exactly REPEAT_CYCLES cycles apart.
REQ-027 Arithmetic SHALL be 4-bit unsigned, with no wrap-around at any boundary.

Reset
REQ-028 While rst is high, the block SHALL hold duty = DUTY_INIT, duty_update = 0 and the FSM in IDLE, and SHALL clear the synchronizers, debounced levels and all counters; at_max and at_min SHALL reflect DUTY_INIT.
REQ-029 When rst asserts mid-operation, the block SHALL abort the current operation immediately; a switch held through reset release SHALL be treated as a new press once it is debounced per REQ-025.

Verification (defaults; duty reset value 5)
REQ-030 Scenario reset: assert rst, release it with both switches low -> duty = 5, duty_update = 0, at_max = 0, at_min = 0, and no change over 100 cycles.
REQ-031 Scenario single press: hold swt_increase high for 10 cycles, then release -> duty = 6 at edge 7 with exactly one duty_update pulse, and no repeat step.
REQ-032 Scenario glitch: pulse swt_decrease high for 3 cycles -> duty stays 5 and no duty_update occurs; then apply bouncing 1-cycle toggles for 20 cycles followed by a stable high -> exactly one decrement, giving duty = 4.
REQ-033 Scenario auto-repeat/saturation: hold swt_increase for 200 cycles -> duty goes 6, 7, 8, 9, 10 with steps 20 cycles apart, at_max = 1 once duty = 10, and no pulses after that.
REQ-034 Scenario lock: press both switches together -> duty is unchanged; release only swt_decrease -> state stays LOCK with no step; release both, then press swt_decrease -> duty decrements by 1.
REQ-035 Scenario reset mid-hold: during DEC_HOLD with duty = 2, assert rst for 2 cycles while the switch stays held -> duty = 5 immediately, then duty = 4 at edge 7 after rst deasserts.
